serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 75 +++++++
 tb/tb_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Wide-frame to word-stream serializer with ready/valid handshakes on both sides.
// Accepts a new frame on the same edge the last word leaves, so back-to-back frames have no bubble.
module serializer #(
  parameter int WIDTH         = 8,
  parameter int NUM_WORDS     = 4,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       i_reset_n,
  input  logic [NUM_WORDS*WIDTH-1:0] i_data,
  input  logic                       i_dv,
  output logic                       o_ready,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_dv,
  output logic                       o_last,
  output logic                       o_drop
);

  localparam int              CNT_W    = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [NUM_WORDS-1:0][WIDTH-1:0]  frame;
  logic [CNT_W-1:0]                 word_idx;
  logic                             last_word;
  logic                             xfer;
  logic                             accept;

  assign o_dv      = (state == SHIFT);
  assign last_word = (cnt == LAST_CNT);
  assign xfer      = o_dv && i_ready;
  assign o_last    = o_dv && last_word;

  // NOTE: o_ready is gated by the reset input itself so upstream sees "not ready"
  // the instant reset asserts, not one edge later.
  assign o_ready = i_reset_n && ((state == IDLE) || (xfer && last_word));
  assign accept  = i_dv && o_ready;

  // Big-endian walks the frame from the top word down using the same counter.
  assign word_idx = LITTLE_ENDIAN ? cnt : (LAST_CNT - cnt);
  assign o_data   = frame[word_idx];

  // NOTE: the frame register is reset too, so o_data reads zero during reset
  // rather than leaking the discarded frame.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      frame  <= '0;
      o_drop <= 1'b0;
    end else begin
      o_drop <= i_dv && !o_ready;
      if (accept) begin
        frame <= i_data;
        cnt   <= '0;
        state <= SHIFT;
      end else if (xfer) begin
        if (last_word) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: one little-endian and one big-endian instance share stimulus;
// a cycle table covers streaming, back-pressure and drops, and a hand sequence covers async reset.
module tb_serializer;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_data;
  logic        i_dv;
  logic        i_ready;

  logic [7:0]  le_data, be_data;
  logic        le_dv, be_dv, le_last, be_last, le_ordy, be_ordy, le_drop, be_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b1)) dut_le (
    .clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_dv(i_dv), .o_ready(le_ordy),
    .i_ready(i_ready), .o_data(le_data), .o_dv(le_dv), .o_last(le_last), .o_drop(le_drop)
  );

  serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_dv(i_dv), .o_ready(be_ordy),
    .i_ready(i_ready), .o_data(be_data), .o_dv(be_dv), .o_last(be_last), .o_drop(be_drop)
  );

  // One row per clock cycle: inputs driven for the cycle, outputs expected before its rising edge.
  typedef struct {
    logic        dv;
    logic        rdy;
    logic [31:0] data;
    logic        e_dv;
    logic [7:0]  e_le;
    logic [7:0]  e_be;
    logic        e_last;
    logic        e_ordy;
    logic        e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input logic rdy, input logic [31:0] data,
                              input logic e_dv, input logic [7:0] e_le, input logic [7:0] e_be,
                              input logic e_last, input logic e_ordy, input logic e_drop);
    vec_t v;
    v.dv = dv; v.rdy = rdy; v.data = data;
    v.e_dv = e_dv; v.e_le = e_le; v.e_be = e_be;
    v.e_last = e_last; v.e_ordy = e_ordy; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks both instances; data compared only while a word is valid.
  task automatic check_both(input string tag, input logic e_dv, input logic [7:0] e_le,
                            input logic [7:0] e_be, input logic e_last, input logic e_ordy,
                            input logic e_drop);
    check({tag, " le o_dv"},    32'(le_dv),   32'(e_dv));
    check({tag, " be o_dv"},    32'(be_dv),   32'(e_dv));
    check({tag, " le o_last"},  32'(le_last), 32'(e_last));
    check({tag, " be o_last"},  32'(be_last), 32'(e_last));
    check({tag, " le o_ready"}, 32'(le_ordy), 32'(e_ordy));
    check({tag, " be o_ready"}, 32'(be_ordy), 32'(e_ordy));
    check({tag, " le o_drop"},  32'(le_drop), 32'(e_drop));
    check({tag, " be o_drop"},  32'(be_drop), 32'(e_drop));
    if (e_dv) begin
      check({tag, " le o_data"}, 32'(le_data), 32'(e_le));
      check({tag, " be o_data"}, 32'(be_data), 32'(e_be));
    end
  endtask

  initial begin
    // Single frame, both byte orders.
    vecs.push_back(mk(1, 1, 32'hDDCCBBAA, 0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hAA, 8'hDD, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hBB, 8'hCC, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hCC, 8'hBB, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hDD, 8'hAA, 1, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0));
    // Back-to-back frames with i_dv held; refused offers raise o_drop the following cycle.
    vecs.push_back(mk(1, 1, 32'h44332211, 0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h88776655, 1, 8'h11, 8'h44, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h88776655, 1, 8'h22, 8'h33, 0, 0, 1));
    vecs.push_back(mk(1, 1, 32'h88776655, 1, 8'h33, 8'h22, 0, 0, 1));
    vecs.push_back(mk(1, 1, 32'h88776655, 1, 8'h44, 8'h11, 1, 1, 1));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h55, 8'h88, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h66, 8'h77, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h77, 8'h66, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h88, 8'h55, 1, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0));
    // Back-pressure on the second word, then on the last word.
    vecs.push_back(mk(1, 1, 32'hDDCCBBAA, 0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hAA, 8'hDD, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 8'hBB, 8'hCC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 8'hBB, 8'hCC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 8'hBB, 8'hCC, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hBB, 8'hCC, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hCC, 8'hBB, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 8'hDD, 8'hAA, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'hDD, 8'hAA, 1, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0));
    // Offer refused mid-frame: single drop pulse, current frame undisturbed.
    vecs.push_back(mk(1, 1, 32'h44332211, 0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h11, 8'h44, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h88776655, 1, 8'h22, 8'h33, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h33, 8'h22, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h0,        1, 8'h44, 8'h11, 1, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0));

    // Reset state, checked while reset is held and before any clock edge.
    i_reset_n = 1'b0;
    i_dv      = 1'b0;
    i_ready   = 1'b1;
    i_data    = 32'h0;
    #1;
    check_both("reset", 0, 8'h00, 8'h00, 0, 0, 0);
    check("reset le o_data", 32'(le_data), 32'h0);
    check("reset be o_data", 32'(be_data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      i_dv    = vecs[i].dv;
      i_ready = vecs[i].rdy;
      i_data  = vecs[i].data;
      #1;
      check_both($sformatf("vec%0d", i), vecs[i].e_dv, vecs[i].e_le, vecs[i].e_be,
                 vecs[i].e_last, vecs[i].e_ordy, vecs[i].e_drop);
    end

    // Async reset while the third word is presented: outputs drop without a clock edge.
    @(negedge clk);
    i_dv = 1'b1; i_ready = 1'b1; i_data = 32'hDDCCBBAA;
    @(negedge clk);
    i_dv = 1'b0;
    #1 check_both("rst_seq w0", 1, 8'hAA, 8'hDD, 0, 0, 0);
    @(negedge clk);
    #1 check_both("rst_seq w1", 1, 8'hBB, 8'hCC, 0, 0, 0);
    @(negedge clk);
    #1 check_both("rst_seq w2", 1, 8'hCC, 8'hBB, 0, 0, 0);
    #2 i_reset_n = 1'b0;
    #1;
    check_both("rst_seq async", 0, 8'h00, 8'h00, 0, 0, 0);
    check("rst_seq le o_data", 32'(le_data), 32'h0);
    check("rst_seq be o_data", 32'(be_data), 32'h0);
    @(negedge clk);
    i_reset_n = 1'b1;
    i_dv = 1'b1; i_data = 32'h44332211;
    #1 check_both("rst_seq after", 0, 8'h00, 8'h00, 0, 1, 0);
    @(negedge clk);
    i_dv = 1'b0;
    #1 check_both("rst_seq n0", 1, 8'h11, 8'h44, 0, 0, 0);
    @(negedge clk);
    #1 check_both("rst_seq n1", 1, 8'h22, 8'h33, 0, 0, 0);
    @(negedge clk);
    #1 check_both("rst_seq n2", 1, 8'h33, 8'h22, 0, 0, 0);
    @(negedge clk);
    #1 check_both("rst_seq n3", 1, 8'h44, 8'h11, 1, 1, 0);
    @(negedge clk);
    #1 check_both("rst_seq idle", 0, 8'h00, 8'h00, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
